// File: rtl/reg_bus_initiator.sv
// Single-outstanding initiator for the valid/ready register bus: one host command -> one bus transaction -> one response.
// Optional request timeout is compiled in with REG_BUS_INIT_TIMEOUT_EN.
module reg_bus_initiator #(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_W          = 9
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    if (2 ** CNT_W <= TIMEOUT_CYCLES) begin : g_cfg_check
        $error("CNT_W too narrow for TIMEOUT_CYCLES");
    end

    state_t      r_state;
    state_t      w_next_state;
    logic        r_cmd_ready;
    logic        r_mem_valid;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [3:0]  r_mem_wstrb;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_rdata;
    logic        w_cmd_hs;
    logic        w_rsp_hs;
    logic        w_mem_done;
    logic        w_timeout;
    logic        w_unused;

    assign w_unused   = ^cmd_addr[1:0];
    assign w_cmd_hs   = cmd_valid & r_cmd_ready;
    assign w_rsp_hs   = r_rsp_valid & rsp_ready;
    // Ready is only meaningful in REQ; a responder's late ready in RESP/IDLE is ignored.
    assign w_mem_done = (r_state == ST_REQ) & mem_ready;

`ifdef REG_BUS_INIT_TIMEOUT_EN
    logic [CNT_W-1:0] r_cnt;
    logic             r_rsp_err;

    assign w_timeout = (r_state == ST_REQ) & ~mem_ready
                     & (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign rsp_err   = r_rsp_err;

    // Cycles spent in REQ for the current request.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (w_cmd_hs) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (r_state == ST_REQ) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    // Error flag of the pending response.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rsp_err <= 1'b0;
        end else if (w_mem_done) begin
            r_rsp_err <= 1'b0;
        end else if (w_timeout) begin
            r_rsp_err <= 1'b1;
        end else begin
            r_rsp_err <= r_rsp_err;
        end
    end
`else
    assign w_timeout = 1'b0;
    assign rsp_err   = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_cmd_hs) w_next_state = ST_REQ;
                else          w_next_state = ST_IDLE;
            end
            ST_REQ: begin
                if (w_mem_done || w_timeout) w_next_state = ST_RESP;
                else                         w_next_state = ST_REQ;
            end
            ST_RESP: begin
                if (w_rsp_hs) w_next_state = ST_IDLE;
                else          w_next_state = ST_RESP;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Bus request and response registers; cmd_ready stays low until the first edge after reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cmd_ready <= 1'b0;
            r_mem_valid <= 1'b0;
            r_mem_addr  <= 32'h0000_0000;
            r_mem_wdata <= 32'h0000_0000;
            r_mem_wstrb <= 4'b0000;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'h0000_0000;
        end else begin
            r_cmd_ready <= (w_next_state == ST_IDLE);
            if (w_cmd_hs) begin
                r_mem_addr  <= {cmd_addr[31:2], 2'b00};
                r_mem_wdata <= cmd_wdata;
                r_mem_wstrb <= cmd_wstrb;
                r_mem_valid <= 1'b1;
            end else if (w_mem_done) begin
                r_rsp_rdata <= mem_rdata;
                r_mem_valid <= 1'b0;
                r_mem_wstrb <= 4'b0000;
                r_rsp_valid <= 1'b1;
            end else if (w_timeout) begin
                r_rsp_rdata <= 32'h0000_0000;
                r_mem_valid <= 1'b0;
                r_rsp_valid <= 1'b1;
            end else if (w_rsp_hs) begin
                r_rsp_valid <= 1'b0;
            end else begin
                r_rsp_valid <= r_rsp_valid;
            end
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign mem_valid = r_mem_valid;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_wstrb = r_mem_wstrb;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_reg_bus_initiator.sv
// Bench for reg_bus_initiator: registered responder with programmable wait/stale-ready/hang,
// word-array reference memory, directed and random commands.
module tb_reg_bus_initiator;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        resetn;
    logic        cmd_valid, cmd_ready;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic        mem_valid, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    reg_bus_initiator #(.TIMEOUT_CYCLES(TO), .CNT_W(4)) dut (
        .clk(clk), .resetn(resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_rsp = 0;
    int rsp_seen = 0;

    int resp_extra = 0;
    bit resp_stale = 1'b0;
    bit resp_hang  = 1'b0;
    int resp_cnt;
    bit stale_ph;
    logic [31:0] bus_mem [256];
    logic [31:0] ref_mem [256];

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // Responder: bus memory powers up with word index as content; ack after resp_extra cycles.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_ready <= 1'b0;
            mem_rdata <= 32'h0;
            resp_cnt  <= 0;
            stale_ph  <= 1'b0;
            for (int i = 0; i < 256; i++) bus_mem[i] <= 32'(i);
        end else if (mem_ready) begin
            if (resp_stale && !stale_ph) stale_ph <= 1'b1;
            else begin
                mem_ready <= 1'b0;
                stale_ph  <= 1'b0;
            end
        end else if (mem_valid && !resp_hang) begin
            if (resp_cnt >= resp_extra) begin
                mem_ready <= 1'b1;
                resp_cnt  <= 0;
                mem_rdata <= bus_mem[mem_addr[9:2]];
                bus_mem[mem_addr[9:2]] <= merge(bus_mem[mem_addr[9:2]], mem_wdata, mem_wstrb);
            end else resp_cnt <= resp_cnt + 1;
        end else resp_cnt <= 0;
    end

    // Response handshake counter.
    always @(posedge clk) if (resetn && rsp_valid && rsp_ready) rsp_seen <= rsp_seen + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'(i);
    endtask

    // Present a command (called at a negedge) and return at the negedge after acceptance.
    task automatic issue_cmd(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input bit hold);
        int n;
        cmd_valid = 1'b1; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        n = 0;
        while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
        check("cmd_accept", {31'b0, cmd_ready}, 32'd1);
        @(negedge clk);
        if (!hold) cmd_valid = 1'b0;
    endtask

    task automatic run_cmd(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int extra, input int bp, input bit stale, input bit hold);
        int n, hi;
        bit ok;
        logic [31:0] exp_rd, exp_addr;
        exp_addr = {a[31:2], 2'b00};
        exp_rd   = ref_mem[a[9:2]];
        ref_mem[a[9:2]] = merge(ref_mem[a[9:2]], d, s);
        resp_extra = extra; resp_stale = stale; resp_hang = 1'b0;
        issue_cmd(a, d, s, hold);
        n = 0; hi = 0; ok = 1'b1;
        while (!rsp_valid && n < 64) begin
            if (mem_valid) begin
                hi++;
                if (mem_addr !== exp_addr || mem_wdata !== d || mem_wstrb !== s) ok = 1'b0;
            end
            if (cmd_ready) ok = 1'b0;
            @(negedge clk); n++;
        end
        check("rsp_latency", n, 32'(extra + 2));
        check("mem_valid_cycles", hi, 32'(extra + 2));
        check("req_stable", {31'b0, ok}, 32'd1);
        check("rsp_rdata", rsp_rdata, exp_rd);
        check("rsp_err", {31'b0, rsp_err}, 32'd0);
        check("mem_valid_in_resp", {31'b0, mem_valid}, 32'd0);
        check("mem_wstrb_cleared", {28'b0, mem_wstrb}, 32'd0);
        ok = 1'b1;
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            if (!rsp_valid || rsp_rdata !== exp_rd || cmd_ready || mem_valid) ok = 1'b0;
        end
        if (bp > 0) check("backpressure_hold", {31'b0, ok}, 32'd1);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        exp_rsp++;
        check("rsp_valid_drop", {31'b0, rsp_valid}, 32'd0);
        check("cmd_ready_after_rsp", {31'b0, cmd_ready}, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n, hi;
        bit ok;
        logic [31:0] a;
        logic [3:0]  s;
        resetn = 1'b0; cmd_valid = 1'b0; cmd_addr = 32'h0; cmd_wdata = 32'h0;
        cmd_wstrb = 4'h0; rsp_ready = 1'b0;
        reset_model();
        repeat (3) @(negedge clk);
        check("reset_mem_valid", {31'b0, mem_valid}, 32'd0);
        check("reset_mem_addr", mem_addr, 32'h0);
        check("reset_mem_wdata", mem_wdata, 32'h0);
        check("reset_mem_wstrb", {28'b0, mem_wstrb}, 32'd0);
        check("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("reset_rsp_rdata", rsp_rdata, 32'h0);
        check("reset_rsp_err", {31'b0, rsp_err}, 32'd0);
        check("reset_cmd_ready", {31'b0, cmd_ready}, 32'd0);
        resetn = 1'b1;
        @(negedge clk);
        check("release_cmd_ready", {31'b0, cmd_ready}, 32'd1);

        // Read of word 0x1000_0004 (content 1), zero-wait responder.
        run_cmd(32'h1000_0007, 32'h0, 4'b0000, 0, 0, 1'b0, 1'b0);
        // Byte write with waits: valid high 5 cycles.
        run_cmd(32'h1000_0008, 32'h0000_0001, 4'b0001, 3, 0, 1'b0, 1'b0);
        run_cmd(32'h1000_0008, 32'h0, 4'b0000, 0, 0, 1'b0, 1'b0);
        // Back-pressure with cmd_valid held, then immediate next command.
        run_cmd(32'h1000_0010, 32'hDEAD_BEEF, 4'b1111, 1, 10, 1'b0, 1'b1);
        run_cmd(32'h1000_0010, 32'h0, 4'b0000, 0, 0, 1'b0, 1'b0);
        // Stale ready, back-to-back.
        for (int i = 0; i < 4; i++)
            run_cmd(32'h1000_0020 + 32'(4 * i), 32'hA5A5_0000 + 32'(i), 4'(i * 5), 0, 0, 1'b1, 1'b0);

        for (int i = 0; i < 40; i++) begin
            a = 32'h1000_0000 | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            s = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
            run_cmd(a, $urandom, s, $urandom_range(0, 3), $urandom_range(0, 3),
                    1'($urandom_range(0, 1)), 1'b0);
        end

        resp_hang = 1'b1;
        issue_cmd(32'h1000_0040, 32'h0, 4'b0000, 1'b0);
`ifdef REG_BUS_INIT_TIMEOUT_EN
        n = 0; hi = 0;
        while (!rsp_valid && n < 64) begin
            if (mem_valid) hi++;
            @(negedge clk); n++;
        end
        check("timeout_mem_valid_cycles", hi, 32'(TO));
        check("timeout_rsp_err", {31'b0, rsp_err}, 32'd1);
        check("timeout_rsp_rdata", rsp_rdata, 32'h0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        exp_rsp++;
        issue_cmd(32'h1000_0044, 32'h0, 4'b0000, 1'b0);
`else
        ok = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            if (!mem_valid || rsp_valid) ok = 1'b0;
            @(negedge clk);
        end
        check("no_timeout_hang", {31'b0, ok}, 32'd1);
`endif
        // Reset in the middle of a hung request.
        repeat (3) @(negedge clk);
        check("pre_reset_mem_valid", {31'b0, mem_valid}, 32'd1);
        #2 resetn = 1'b0;
        #1;
        check("midreset_mem_valid", {31'b0, mem_valid}, 32'd0);
        check("midreset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("midreset_cmd_ready", {31'b0, cmd_ready}, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        resp_hang = 1'b0;
        reset_model();
        @(negedge clk);
        check("post_reset_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        run_cmd(32'h1000_0004, 32'h0, 4'b0000, 0, 0, 1'b0, 1'b0);
        @(negedge clk);
        check("rsp_count", rsp_seen, exp_rsp);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
